status_uart_tx: RTL and testbench
=================================

// Module: status_uart_tx
// PURPOSE
//  Byte-wide UART transmitter with small TX FIFO, 8N1 framing, LSB first.
//  Sits in the user project next to the TMS1x00 core. Streams status/debug bytes
//  (test stage codes, error reports) from firmware-visible logic to a GPIO pad.
//  The bench UART receiver on that pad decodes them.
//  Bit period is set at runtime through a divisor input.
// PARAMETERS
//  FIFO_DEPTH   8    TX FIFO entries; power of two, >= 2
//  DIV_W        16   width of bit-period divisor
// PORTS
//  wb_clk_i     in   1        system clock
//  wb_rst_i     in   1        async reset, active-high
//  div_i        in   DIV_W    bit period = div_i+1 clocks; sampled at frame start
//  wr_en_i      in   1        push wr_data_i into FIFO this cycle
//  wr_data_i    in   8        byte to send
//  full_o       out  1        FIFO full; write this cycle is dropped
//  empty_o      out  1        FIFO empty
//  busy_o       out  1        frame in progress (state != IDLE)
//  ovf_o        out  1        sticky: write attempted while full
//  tx_o         out  1        serial line, idle high
// BEHAVIOUR
//  Reset (async): tx_o=1, busy_o=0, ovf_o=0, empty_o=1, full_o=0, FIFO pointers cleared, state IDLE.
//  Reset mid-frame aborts the frame immediately; tx_o returns high with no glitch low.
//  FIFO: registered write at the edge where wr_en_i=1 and !full_o.
//   - full_o/empty_o are computed from pointers before the edge.
//   - Write when full is dropped even if a pop occurs on the same edge; ovf_o is set.
//   - Simultaneous push+pop when non-full and non-empty: count unchanged.
//   - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
//  FSM states: IDLE, START, DATA, STOP (plus PARITY, see CONFIGURATION).
//   - IDLE: if !empty_o, pop the head into the shift reg, latch div_i into the period reload, tx_o<=0, go START.
//   - Each state holds for exactly div_i+1 clocks, using a down-counter reloaded from the latched divisor.
//   - START -> DATA: shift 8 bits LSB first; a 3-bit index counts 0..7.
//   - DATA -> STOP (tx_o=1) -> IDLE.
//   - If the FIFO is non-empty when STOP expires, the next byte pops directly (back-to-back).
//     IDLE is skipped and there are no extra idle cycles between frames.
//  Latency: byte written at edge N into an empty FIFO while IDLE -> tx_o falls after edge N+1.
//  Frame length = 10*(div_i+1) clocks; div_i=0 gives 1 clock per bit.
//  A div_i change mid-frame has no effect until the next frame.
//  busy_o=1 from the pop edge until STOP expires with the FIFO empty.
// CONFIGURATION
//  STATUS_UART_PARITY_EN defined: an even-parity bit is inserted between DATA and STOP.
//   - PARITY state, one bit period, value = ^byte.
//   - Frame length = 11*(div_i+1).
//  Not defined: PARITY state and its logic are absent; 8N1 only.
// STRUCTURE
//  status_uart_pkg holds:
//   - state enum (IDLE, START, DATA, PARITY, STOP)
//   - constants: LINE_IDLE=1'b1, START_BIT=1'b0, DATA_BITS=8
//  Sub-module status_uart_fifo: sync FIFO with full/empty, parameterised by FIFO_DEPTH, width 8.
//  The top holds the FSM, the baud down-counter and the shift register.
// TESTING
//  - div_i=3, write 0x55 -> tx_o low 4 clks, bits 1,0,1,0,1,0,1,0 at 4 clks each, high 4 clks; 40 clks total.
//  - div_i=0, write 0xA3,0x0F,0xFF back-to-back -> three contiguous 10-clk frames, no idle gap, busy_o high 30 clks.
//  - With div_i=1, idle for 9 writes without draining -> first 8 accepted (one already popped by FSM, so 9th also fits);
//    10th write -> full_o=1, ovf_o=1, dropped byte never appears.
//  - Assert wb_rst_i during DATA bit 4 of 0xC3 -> tx_o=1 same cycle, FIFO empty.
//    After release, a new write of 0x81 -> clean frame.
//  - div_i changed 3->7 mid-frame -> current frame stays at 4 clks/bit, next frame at 8.
//  - STATUS_UART_PARITY_EN: 0x07 -> parity bit 1, 11-bit frame; 0x03 -> parity 0.

Source files
------------

// File: rtl/status_uart_pkg.sv
// Shared types and constants for the status UART transmitter.
// Frame states, line levels and data width used by the FSM and the bench-facing top.
package status_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam int   DATA_BITS = 8;
  localparam int   BIT_IDX_W = $clog2(DATA_BITS);

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/status_uart_fifo.sv
// Synchronous FIFO with registered write and combinational head read.
// Latency: 1 clock write-to-visible; backpressure: full drops writes, empty ignores reads.
module status_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra MSB on each pointer tells a full ring from an empty one.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/status_uart_tx.sv
// Byte UART transmitter (8N1, LSB first; even parity bit when STATUS_UART_PARITY_EN is defined).
// Latency: tx_o falls one clock after a write into an empty idle FIFO; backpressure: full_o, writes while full dropped and flagged on ovf_o.
module status_uart_tx
  import status_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             wr_en_i,
  input  logic [7:0]       wr_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic             tx_o
);

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 pop;

  uart_state_t          state, state_nxt;
  logic [DIV_W-1:0]     cnt, cnt_nxt;
  logic [DIV_W-1:0]     period, period_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [BIT_IDX_W-1:0] idx, idx_nxt;
  logic                 tx, tx_nxt;
  logic                 ovf;
  logic                 bit_done;
  logic                 start_frame;
`ifdef STATUS_UART_PARITY_EN
  logic                 par, par_nxt;
`endif

  status_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .wr_vld (wr_en_i),
    .wr_dat (wr_data_i),
    .rd_rdy (pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_done = (cnt == '0);
  assign pop      = start_frame;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      period <= '0;
      shreg  <= '0;
      idx    <= '0;
      tx     <= LINE_IDLE;
`ifdef STATUS_UART_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      period <= period_nxt;
      shreg  <= shreg_nxt;
      idx    <= idx_nxt;
      tx     <= tx_nxt;
`ifdef STATUS_UART_PARITY_EN
      par    <= par_nxt;
`endif
    end
  end

  // Sticky until reset; a write against a full FIFO is lost even if a pop happens on the same edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ovf <= 1'b0;
    end else if (wr_en_i && fifo_full) begin
      ovf <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    period_nxt  = period;
    shreg_nxt   = shreg;
    idx_nxt     = idx;
    tx_nxt      = tx;
    start_frame = 1'b0;
`ifdef STATUS_UART_PARITY_EN
    par_nxt     = par;
`endif

    if (state != IDLE && !bit_done) begin
      cnt_nxt = cnt - DIV_W'(1);
    end

    case (state)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          idx_nxt   = '0;
          cnt_nxt   = period;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_nxt = period;
          if (idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef STATUS_UART_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = par;
`else
            state_nxt = STOP;
            tx_nxt    = LINE_IDLE;
`endif
          end else begin
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
            idx_nxt   = idx + BIT_IDX_W'(1);
          end
        end
      end
`ifdef STATUS_UART_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_nxt = STOP;
          tx_nxt    = LINE_IDLE;
          cnt_nxt   = period;
        end
      end
`endif
      STOP: begin
        // Back-to-back frames: the next byte starts on the edge the stop bit ends.
        if (bit_done) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = LINE_IDLE;
      end
    endcase

    if (start_frame) begin
      state_nxt  = START;
      tx_nxt     = START_BIT;
      shreg_nxt  = fifo_dat;
      period_nxt = div_i;
      cnt_nxt    = div_i;
`ifdef STATUS_UART_PARITY_EN
      par_nxt    = even_parity(fifo_dat);
`endif
    end
  end

  assign tx_o    = tx;
  assign busy_o  = (state != IDLE);
  assign full_o  = fifo_full;
  assign empty_o = fifo_empty;
  assign ovf_o   = ovf;

endmodule

// File: tb/tb_status_uart_tx.sv
// Self-checking bench for status_uart_tx: frame table, directed corner sequences and random traffic
// compared every cycle against a sample-queue model of the serial line.
module tb_status_uart_tx;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
`ifdef STATUS_UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] div;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full, empty, busy, ovf, tx;

  always #5 clk = ~clk;

  status_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DW)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .div_i     (div),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .full_o    (full),
    .empty_o   (empty),
    .busy_o    (busy),
    .ovf_o     (ovf),
    .tx_o      (tx)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted bytes plus the queue of line samples still to be driven.
  logic [7:0] mq[$];
  bit         lq[$];
  bit         m_tx, m_busy, m_ovf;

  function automatic void model_reset();
    mq.delete();
    lq.delete();
    m_tx   = 1'b1;
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit         was_full;
    logic [7:0] b;
    bit         v;
    int         reps;
    if (rst) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (lq.size() == 0 && mq.size() != 0) begin
      b    = mq.pop_front();
      reps = int'(div) + 1;
      for (int k = 0; k < NBITS; k++) begin
        if (k == 0)                v = 1'b0;
        else if (k <= 8)           v = b[k-1];
        else if (PAR && k == 9)    v = ^b;
        else                       v = 1'b1;
        for (int r = 0; r < reps; r++) lq.push_back(v);
      end
    end
    if (wr_en) begin
      if (was_full) m_ovf = 1'b1;
      else          mq.push_back(wr_data);
    end
    if (lq.size() != 0) begin
      m_tx   = lq.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    chk("tx",    {31'd0, tx},    {31'd0, m_tx});
    chk("busy",  {31'd0, busy},  {31'd0, m_busy});
    chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
    chk("full",  {31'd0, full},  {31'd0, mq.size() == DEPTH});
    chk("ovf",   {31'd0, ovf},   {31'd0, m_ovf});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic [9:0]  line;   // start, d0..d7, stop in transmit order, first bit at MSB
    logic        par;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    logic [10:0] got;
    logic [10:0] exp;
    logic        held_ok;
    logic        s;
    got     = '0;
    held_ok = 1'b1;
    exp     = PAR ? {v.line[9:1], v.par, v.line[0]} : {1'b0, v.line};
    div     = v.div;
    write_byte(v.data);
    for (int k = 0; k < NBITS; k++) begin
      for (int j = 0; j <= int'(v.div); j++) begin
        tick();
        s = tx;
        if (j == 0) got[NBITS-1-k] = s;
        else if (s !== got[NBITS-1-k]) held_ok = 1'b0;
      end
    end
    chk($sformatf("frame%0d_bits", id), {21'd0, got}, {21'd0, exp});
    chk($sformatf("frame%0d_hold", id), {31'd0, held_ok}, 32'd1);
    tick();
    chk($sformatf("frame%0d_idle", id), {30'd0, busy, tx}, 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || !empty) && n < budget) begin
      tick();
      n++;
    end
    chk(name, {30'd0, busy, !empty}, 32'd0);
  endtask

  vec_t vecs[6];
  int   busy_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    div     = '0;
    wr_en   = 1'b0;
    wr_data = '0;
    model_reset();

    vecs[0] = '{16'd3, 8'h55, 10'b0101010101, 1'b0};
    vecs[1] = '{16'd0, 8'hA3, 10'b0110001011, 1'b0};
    vecs[2] = '{16'd1, 8'h07, 10'b0111000001, 1'b1};
    vecs[3] = '{16'd2, 8'h03, 10'b0110000001, 1'b0};
    vecs[4] = '{16'd0, 8'h81, 10'b0100000011, 1'b0};
    vecs[5] = '{16'd5, 8'h80, 10'b0000000011, 1'b1};

    // Reset state
    #1;
    chk("rst_outputs", {27'd0, tx, busy, ovf, empty, full}, 32'b10010);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back frames at one clock per bit
    div      = '0;
    busy_cnt = 0;
    wr_en    = 1'b1;
    wr_data  = 8'hA3; tick(); busy_cnt += int'(busy);
    wr_data  = 8'h0F; tick(); busy_cnt += int'(busy);
    wr_data  = 8'hFF; tick(); busy_cnt += int'(busy);
    wr_en    = 1'b0;
    for (int n = 0; n < 200 && busy; n++) begin
      tick();
      busy_cnt += int'(busy);
    end
    chk("b2b_busy_cycles", busy_cnt, 3 * NBITS);
    tick();

    // Overflow: ten writes into a stalled transmitter
    div = 16'd1;
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
      tick();
      if (i == 8) chk("ovf_after9", {30'd0, full, ovf}, 32'b10);
      if (i == 9) chk("ovf_after10", {30'd0, full, ovf}, 32'b11);
    end
    wr_en = 1'b0;
    drain("ovf_drain", 400);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Reset during data bit 4 of 0xC3
    div = 16'd3;
    write_byte(8'hC3);
    repeat (22) tick();
    chk("mid_bit4_low", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_same_cycle", {28'd0, tx, busy, empty, ovf}, 32'b1010);
    tick();
    rst = 1'b0;
    tick();
    run_vec(vecs[4], 6);

    // Divisor change mid-frame only affects the next frame
    div      = 16'd3;
    busy_cnt = 0;
    wr_en    = 1'b1;
    wr_data  = 8'h5A; tick(); busy_cnt += int'(busy);
    wr_data  = 8'h3C; tick(); busy_cnt += int'(busy);
    wr_en    = 1'b0;
    repeat (10) begin
      tick();
      busy_cnt += int'(busy);
    end
    div = 16'd7;
    for (int n = 0; n < 400 && busy; n++) begin
      tick();
      busy_cnt += int'(busy);
    end
    chk("divchg_busy_cycles", busy_cnt, 12 * NBITS);
    tick();

    // Random traffic
    div = 16'(($urandom_range(0, 3)));
    for (int c = 0; c < 800; c++) begin
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 3));
      tick();
    end
    wr_en = 1'b0;
    drain("rand_drain", 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
